// File: rtl/copro_result_queue_if.sv
// copro_result_queue_if -- ALU capture and CV-X-IF result handshake bundle for copro_result_queue.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

interface copro_result_queue_if #(
  parameter int unsigned XLEN     = 32,
  parameter type         hartid_t = logic,
  parameter type         id_t     = logic
);
  logic            alu_valid_i;
  logic [XLEN-1:0] alu_result_i;
  hartid_t         alu_hartid_i;
  id_t             alu_id_i;
  logic [4:0]      alu_rd_i;
  logic            alu_we_i;
  logic            issue_ready_o;
  logic            result_valid_o;
  logic            result_ready_i;
  logic [XLEN-1:0] result_data_o;
  hartid_t         result_hartid_o;
  id_t             result_id_o;
  logic [4:0]      result_rd_o;
  logic            result_we_o;

  // Environment view: ALU producer plus CPU consumer.
  modport master (
    output alu_valid_i, alu_result_i, alu_hartid_i, alu_id_i, alu_rd_i, alu_we_i,
    output result_ready_i,
    input  issue_ready_o,
    input  result_valid_o, result_data_o, result_hartid_o, result_id_o, result_rd_o, result_we_o
  );

  // Queue view.
  modport slave (
    input  alu_valid_i, alu_result_i, alu_hartid_i, alu_id_i, alu_rd_i, alu_we_i,
    input  result_ready_i,
    output issue_ready_o,
    output result_valid_o, result_data_o, result_hartid_o, result_id_o, result_rd_o, result_we_o
  );
endinterface

`default_nettype wire

// File: rtl/copro_result_queue.sv
// copro_result_queue -- in-order FIFO from the non-stallable ALU to the CV-X-IF result port.
// Optional macro COPRO_RESULT_BYPASS_EN: zero-latency bypass when empty. Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module copro_result_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned XLEN     = 32,
  parameter type         hartid_t = logic,
  parameter type         id_t     = logic
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  copro_result_queue_if.slave     bus,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]  mem_data   [DEPTH];
  hartid_t          mem_hartid [DEPTH];
  id_t              mem_id     [DEPTH];
  logic [4:0]       mem_rd     [DEPTH];
  logic [DEPTH-1:0] mem_we;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          bypass_take;
  logic [CW:0]   occupancy_next;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = !empty && bus.result_ready_i;

`ifdef COPRO_RESULT_BYPASS_EN
  assign bypass_take = empty && bus.alu_valid_i && bus.result_ready_i;
`else
  assign bypass_take = 1'b0;
`endif

  // A full queue can still accept a push when the head leaves in the same cycle.
  assign push = bus.alu_valid_i && !bypass_take && (!full || pop);

  // Pops are not credited: the instruction issued now returns next cycle regardless.
  assign occupancy_next    = {1'b0, count_q} + {{CW{1'b0}}, bus.alu_valid_i};
  assign bus.issue_ready_o = (occupancy_next < (CW + 1)'(DEPTH));

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

  always_comb begin
    bus.result_valid_o  = !empty;
    bus.result_data_o   = mem_data[rd_ptr];
    bus.result_hartid_o = mem_hartid[rd_ptr];
    bus.result_id_o     = mem_id[rd_ptr];
    bus.result_rd_o     = mem_rd[rd_ptr];
    bus.result_we_o     = mem_we[rd_ptr];
`ifdef COPRO_RESULT_BYPASS_EN
    if (empty && bus.alu_valid_i) begin
      bus.result_valid_o  = 1'b1;
      bus.result_data_o   = bus.alu_result_i;
      bus.result_hartid_o = bus.alu_hartid_i;
      bus.result_id_o     = bus.alu_id_i;
      bus.result_rd_o     = bus.alu_rd_i;
      bus.result_we_o     = bus.alu_we_i;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mem_we     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data[i]   <= '0;
        mem_hartid[i] <= '0;
        mem_id[i]     <= '0;
        mem_rd[i]     <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr]   <= bus.alu_result_i;
        mem_hartid[wr_ptr] <= bus.alu_hartid_i;
        mem_id[wr_ptr]     <= bus.alu_id_i;
        mem_rd[wr_ptr]     <= bus.alu_rd_i;
        mem_we[wr_ptr]     <= bus.alu_we_i;
        wr_ptr             <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      if (bus.alu_valid_i && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_copro_result_queue.sv
// tb_copro_result_queue -- scoreboard bench for copro_result_queue (DEPTH=4).
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_copro_result_queue;

  localparam int DEPTH = 4;
`ifdef COPRO_RESULT_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef logic [1:0] hart_t;
  typedef logic [3:0] iid_t;

  typedef struct packed {
    logic [31:0] data;
    hart_t       hartid;
    iid_t        id;
    logic [4:0]  rd;
    logic        we;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] count;
  logic       overflow;

  copro_result_queue_if #(.XLEN(32), .hartid_t(hart_t), .id_t(iid_t)) bus();

  copro_result_queue #(
    .DEPTH    (DEPTH),
    .XLEN     (32),
    .hartid_t (hart_t),
    .id_t     (iid_t)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .count_o    (count),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;

  entry_t sb[$];
  int     checks    = 0;
  int     failures  = 0;
  int     delivered = 0;
  entry_t mon_got;
  entry_t mon_exp;

  // Every accepted result must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.result_valid_o && bus.result_ready_i) begin
      mon_got = {bus.result_data_o, bus.result_hartid_o, bus.result_id_o,
                 bus.result_rd_o, bus.result_we_o};
      checks++;
      delivered++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected got=%h required=none", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL result_fields got=%h required=%h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] d, input hart_t h, input iid_t id,
                       input logic [4:0] rd, input logic we, input bit store);
    bus.alu_valid_i  = 1'b1;
    bus.alu_result_i = d;
    bus.alu_hartid_i = h;
    bus.alu_id_i     = id;
    bus.alu_rd_i     = rd;
    bus.alu_we_i     = we;
    if (store) sb.push_back({d, h, id, rd, we});
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.alu_valid_i = 1'b0;
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < DEPTH; i++) begin
      drive(32'hB000_0000 + 32'(base + i), hart_t'(i), iid_t'(base + i), 5'(i + 1), 1'b1, 1'b1);
      tick();
    end
  endtask

  task automatic drain_wait();
    bus.result_ready_i = 1'b1;
    for (int k = 0; k < 2 * DEPTH + 4; k++) begin
      @(negedge clk);
      if (count === 3'd0 && !bus.result_valid_o) break;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n              = 1'b0;
    bus.alu_valid_i    = 1'b0;
    bus.alu_result_i   = '0;
    bus.alu_hartid_i   = '0;
    bus.alu_id_i       = '0;
    bus.alu_rd_i       = '0;
    bus.alu_we_i       = 1'b0;
    bus.result_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.result_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b required=0", bus.result_valid_o);
    end
    checks++;
    if ({bus.result_data_o, bus.result_hartid_o, bus.result_id_o, bus.result_rd_o, bus.result_we_o} !== '0) begin
      failures++; $display("FAIL reset_fields got=%h required=0", bus.result_data_o);
    end
    checks++;
    if (count !== 3'd0 || overflow !== 1'b0) begin
      failures++; $display("FAIL reset_count got=%0d/%b required=0/0", count, overflow);
    end
    checks++;
    if (bus.issue_ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_issue_ready got=%b required=1", bus.issue_ready_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int d0;
    d0 = delivered;
    bus.result_ready_i = 1'b1;
    drive(32'h1234_5678, 2'd1, 4'd3, 5'd5, 1'b1, 1'b1);
    checks++;
    if (bus.result_valid_o !== BYPASS) begin
      failures++; $display("FAIL single_valid_cycle0 got=%b required=%b", bus.result_valid_o, BYPASS);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.result_valid_o !== !BYPASS) begin
      failures++; $display("FAIL single_valid_cycle1 got=%b required=%b", bus.result_valid_o, !BYPASS);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.result_valid_o !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL single_after got=%b/%0d required=0/0", bus.result_valid_o, count);
    end
    checks++;
    if (delivered - d0 !== 1) begin
      failures++; $display("FAIL single_delivered got=%0d required=1", delivered - d0);
    end
    tick();
  endtask

  task automatic test_fill_drain();
    int d0;
    d0 = delivered;
    bus.result_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(32'hA000_0000 + 32'(i), hart_t'(i), iid_t'(i), 5'(i + 1), 1'b1, 1'b1);
      checks++;
      if (bus.issue_ready_o !== (i < DEPTH - 1)) begin
        failures++; $display("FAIL fill_issue_ready i=%0d got=%b required=%b", i, bus.issue_ready_o, i < DEPTH - 1);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (count !== 3'd4 || bus.issue_ready_o !== 1'b0 || bus.result_id_o !== 4'd0) begin
      failures++; $display("FAIL fill_full got=%0d/%b/%0d required=4/0/0", count, bus.issue_ready_o, bus.result_id_o);
    end
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd0 || bus.result_data_o !== 32'hA000_0000) begin
      failures++; $display("FAIL fill_stable got=%0d/%h required=0/a0000000", bus.result_id_o, bus.result_data_o);
    end
    tick();
    drain_wait();
    checks++;
    if (count !== 3'd0 || sb.size() != 0 || delivered - d0 !== 4) begin
      failures++; $display("FAIL fill_drain got=%0d/%0d required=0/4", count, delivered - d0);
    end
    tick();
  endtask

  task automatic test_full_push_pop();
    int d0;
    d0 = delivered;
    bus.result_ready_i = 1'b0;
    fill(0);
    bus.result_ready_i = 1'b1;
    drive(32'hC000_0007, 2'd3, 4'd7, 5'd7, 1'b1, 1'b1);
    checks++;
    if (count !== 3'd4 || bus.issue_ready_o !== 1'b0) begin
      failures++; $display("FAIL pushpop_before got=%0d/%b required=4/0", count, bus.issue_ready_o);
    end
    tick();
    bus.result_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 3'd4 || overflow !== 1'b0 || bus.result_id_o !== 4'd1) begin
      failures++; $display("FAIL pushpop_after got=%0d/%b/%0d required=4/0/1", count, overflow, bus.result_id_o);
    end
    tick();
    drain_wait();
    checks++;
    if (count !== 3'd0 || sb.size() != 0 || delivered - d0 !== 5) begin
      failures++; $display("FAIL pushpop_drain got=%0d/%0d required=0/5", count, delivered - d0);
    end
    tick();
  endtask

  task automatic test_overflow();
    bus.result_ready_i = 1'b0;
    fill(8);
    drive(32'hDEAD_000C, 2'd0, 4'd12, 5'd12, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || count !== 3'd4) begin
      failures++; $display("FAIL overflow_set got=%b/%0d required=1/4", overflow, count);
    end
    tick();
    tick();
    drain_wait();
    checks++;
    if (overflow !== 1'b1 || count !== 3'd0 || sb.size() != 0) begin
      failures++; $display("FAIL overflow_sticky got=%b/%0d required=1/0", overflow, count);
    end
    tick();
  endtask

  task automatic test_nop();
    int d0;
    d0 = delivered;
    bus.result_ready_i = 1'b1;
    drive(32'h0000_BEEF, 2'd2, 4'd5, 5'd0, 1'b0, 1'b1);
    tick();
    drain_wait();
    checks++;
    if (delivered - d0 !== 1 || sb.size() != 0) begin
      failures++; $display("FAIL nop_delivered got=%0d required=1", delivered - d0);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int d0;
    bus.result_ready_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(32'hE000_0000 + 32'(i), hart_t'(i), iid_t'(i), 5'(i), 1'b1, 1'b1);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.result_valid_o !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) begin
      failures++; $display("FAIL reset_mid got=%b/%0d/%b required=0/0/0", bus.result_valid_o, count, overflow);
    end
    sb.delete();
    d0 = delivered;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.result_ready_i = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (bus.result_valid_o !== 1'b0 || count !== 3'd0 || delivered != d0) begin
      failures++; $display("FAIL reset_mid_after got=%b/%0d/%0d required=0/0/0", bus.result_valid_o, count, delivered - d0);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_push_pop();
    test_overflow();
    test_nop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/copro_result_queue.md
# copro_result_queue

Result buffer between the coprocessor ALU's registered output stage and the CV-X-IF result interface toward the CPU. It captures every valid ALU result (hartid, id, rd, we, data) into a FIFO, presents entries in order on a valid/ready result port, and throttles coprocessor issue so the ALU, which cannot be stalled, never produces a result the queue cannot store.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- XLEN, 32, result data width
- hartid_t, logic, hart identifier type
- id_t, logic, instruction identifier type

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- alu_valid_i  in  1  ALU result valid (one-cycle pulse per instruction, no backpressure)
- alu_result_i  in  XLEN  ALU result data
- alu_hartid_i  in  hartid_t  ALU hart id
- alu_id_i  in  id_t  ALU instruction id
- alu_rd_i  in  5  destination register
- alu_we_i  in  1  register write enable
- issue_ready_o  out  1  issue stage may hand a new instruction to the ALU this cycle
- result_valid_o  out  1  head entry valid toward CPU
- result_ready_i  in  1  CPU accepts head entry
- result_data_o  out  XLEN  head data
- result_hartid_o  out  hartid_t  head hart id
- result_id_o  out  id_t  head instruction id
- result_rd_o  out  5  head rd
- result_we_o  out  1  head write enable
- count_o  out  $clog2(DEPTH)+1  occupied entries
- overflow_o  out  1  sticky: a push was dropped

## Operation
- Storage: DEPTH entries of {data, hartid, id, rd, we}; write pointer, read pointer ($clog2(DEPTH) bits, natural wrap), count register 0..DEPTH.
- Push: alu_valid_i=1 in a cycle. Every valid result is stored, including we=0 (NOP) results; entries are never filtered.
- Pop: result_valid_o & result_ready_i in a cycle; read pointer advances, count decrements.
- Push and pop same cycle: both take effect, count unchanged; allowed at count=DEPTH (head leaves, new entry written to freed slot).
- Push at count=DEPTH without pop: entry dropped, pointers and count unchanged, overflow_o set and held until reset.
- result_valid_o = (count != 0). Result outputs are driven from the slot at the read pointer; when empty they show that slot's stale contents (all zero after reset).
- issue_ready_o = (count_q + alu_valid_i) < DEPTH, combinational. Accounts for the entry being pushed this cycle and the instruction issued this cycle that returns from the ALU next cycle; pops are not credited. With correct issue gating, overflow never occurs.
- Order strictly FIFO; no reordering by hartid or id.

## Timing
- Reset: result_valid_o=0, all result_* outputs 0, count_o=0, overflow_o=0, pointers 0, storage cleared; issue_ready_o=1 while alu_valid_i=0.
- Without bypass: an entry pushed at edge N is visible on result_* from cycle N+1; minimum ALU-to-CPU latency 1 cycle.
- result_* outputs stay stable while result_valid_o=1 and result_ready_i=0.
- result_ready_i may be asserted before result_valid_o; it has no effect when empty.
- Reset asserted mid-operation: all entries discarded immediately; no partial pops.

## Configuration
- COPRO_RESULT_BYPASS_EN defined: when count=0 and alu_valid_i=1, the result port is driven directly from the alu_* inputs with result_valid_o=1 in the same cycle. If result_ready_i=1 the entry is consumed and not stored (count stays 0). Otherwise it is stored as a normal push. Zero-cycle latency.
- Undefined: outputs come only from storage; result_valid_o depends only on count. No combinational path from alu_* to result_*.

## Test plan
- Reset, then single ALU result (data 0x1234_5678, id 3, rd 5, we 1) with result_ready_i=1 -> result_valid_o high for exactly one cycle the next cycle (same cycle if bypass) with matching fields; count_o returns to 0.
- Hold result_ready_i=0, push 4 results ids 0..3 (DEPTH=4) -> count_o=4; issue_ready_o falls when count_q+alu_valid_i reaches 4; on release, ids pop out 0,1,2,3 in order.
- Full queue, same-cycle push id 7 and pop -> count_o stays 4, overflow_o stays 0; id 7 emerges last.
- Full queue, push without pop -> overflow_o=1 and stays 1; count_o=4; the dropped id never appears.
- NOP result (we=0, rd=0) -> delivered with result_we_o=0, not filtered.
- Assert rst_ni low with 3 entries queued -> result_valid_o=0 and count_o=0 immediately; queued entries never appear after reset release.
